cpu_run_ctrl: RTL and testbench

//  Run controller sequencing one cpu_32bit instance for a host/testbench.

---
 rtl/cpu_run_ctrl_pkg.sv | 18 +
 rtl/cpu_run_ctrl_cycle_counter.sv | 42 ++++
 rtl/cpu_run_ctrl.sv | 154 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state encoding and a busy decode helper.
package cpu_run_ctrl_pkg;

  // Fixed 3-bit encoding so the state value is stable across tools and debug views.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRstHold = 3'd1,
    StRun     = 3'd2,
    StDone    = 3'd3,
    StTmo     = 3'd4
  } run_state_e;

  // A run is in flight while the CPU is held in reset or executing.
  function automatic logic state_is_busy(run_state_e s);
    return (s == StRstHold) || (s == StRun);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_cycle_counter.sv
// Saturating run-cycle counter with clear, enable and an equality-to-limit flag.
module cpu_run_ctrl_cycle_counter
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;

  // Incremented value, pinned at all-ones so the count never wraps.
  always_comb begin
    count_inc = count_q;
    if (count_q != {CNT_W{1'b1}}) begin
      count_inc = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Flags the cycle whose increment lands exactly on the limit.
  assign hit_o   = (count_inc == limit_i);
  assign count_o = count_q;

  // Count state: clear wins over enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_inc;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: owns the CPU reset, muxes host program loads onto the instruction-memory
// write port, launches runs and reports HALT / timeout / abort outcome with the final PC.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_AW     = 8,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               host_we,
  input  logic [IMEM_AW-1:0] host_addr,
  input  logic [31:0]        host_wdata,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_rst,
  input  logic               cpu_halted,
  input  logic [31:0]        cpu_pc,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               load_rej,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [31:0]        final_pc
);

  localparam int unsigned     HoldW      = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldInit  = HoldW'(RST_CYCLES);
  localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_CYC);

  run_state_e         state_q;
  logic [HoldW-1:0]   hold_q;
  logic               cpu_rst_q;
  logic               imem_we_q;
  logic [IMEM_AW-1:0] imem_waddr_q;
  logic [31:0]        imem_wdata_q;
  logic               done_q;
  logic               timeout_q;
  logic               load_rej_q;
  logic [31:0]        final_pc_q;

  logic cnt_clear;
  logic cnt_en;
  logic cnt_hit;
  logic launch;

  // A launch is accepted only from a resting state and loses to a simultaneous abort.
  assign launch    = start && !abort &&
                     (state_q == StIdle || state_q == StDone || state_q == StTmo);
  assign cnt_clear = launch;
  assign cnt_en    = (state_q == StRun) && !abort && !cpu_halted;

  cpu_run_ctrl_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .limit_i (TimeoutLim),
    .count_o (cycle_count),
    .hit_o   (cnt_hit)
  );

  // FSM, host-load mux and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      cpu_rst_q    <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      load_rej_q   <= 1'b0;
      final_pc_q   <= '0;
    end else begin
      // Host writes pass through only while no run is in flight.
      if (!state_is_busy(state_q)) begin
        imem_we_q    <= host_we;
        imem_waddr_q <= host_addr;
        imem_wdata_q <= host_wdata;
        load_rej_q   <= 1'b0;
      end else begin
        imem_we_q    <= 1'b0;
        load_rej_q   <= host_we;
      end

      case (state_q)
        StIdle, StDone, StTmo: begin
          if (abort) begin
            state_q   <= StIdle;
            cpu_rst_q <= 1'b1;
          end else if (start) begin
            state_q    <= StRstHold;
            hold_q     <= HoldInit;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            final_pc_q <= '0;
          end
        end
        StRstHold: begin
          if (abort) begin
            state_q   <= StIdle;
            cpu_rst_q <= 1'b1;
          end else if (hold_q <= 1) begin
            state_q   <= StRun;
            cpu_rst_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        StRun: begin
          if (abort) begin
            state_q   <= StIdle;
            cpu_rst_q <= 1'b1;
          end else if (cpu_halted) begin
            // CPU stays out of reset so its state can be inspected.
            state_q    <= StDone;
            done_q     <= 1'b1;
            final_pc_q <= cpu_pc;
          end else if (cnt_hit) begin
            state_q    <= StTmo;
            timeout_q  <= 1'b1;
            final_pc_q <= cpu_pc;
            cpu_rst_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          cpu_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign busy       = state_is_busy(state_q);
  assign cpu_rst    = cpu_rst_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign load_rej   = load_rej_q;
  assign final_pc   = final_pc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny behavioural CPU standing in for cpu_32bit.
module tb_cpu_run_ctrl;

  localparam int unsigned IMEM_AW = 8;
  localparam int unsigned CNT_W   = 32;

  localparam logic [31:0] InstrAddi = 32'h2001_0005; // ADDI r1,r0,5
  localparam logic [31:0] InstrHalt = 32'hFC00_0000; // HALT
  localparam logic [31:0] InstrJmp0 = 32'h0800_0000; // JMP 0

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               host_we = 1'b0;
  logic [IMEM_AW-1:0] host_addr = '0;
  logic [31:0]        host_wdata = '0;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [31:0]        imem_wdata;
  logic               cpu_rst;
  logic               cpu_halted;
  logic [31:0]        cpu_pc;
  logic               busy;
  logic               done;
  logic               timeout;
  logic               load_rej;
  logic [CNT_W-1:0]   cycle_count;
  logic [31:0]        final_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .IMEM_AW     (IMEM_AW),
    .RST_CYCLES  (2),
    .TIMEOUT_CYC (16),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .cpu_rst     (cpu_rst),
    .cpu_halted  (cpu_halted),
    .cpu_pc      (cpu_pc),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .load_rej    (load_rej),
    .cycle_count (cycle_count),
    .final_pc    (final_pc)
  );

  // Behavioural CPU: HALT sets halted and advances PC, JMP loads the target, others step by 4.
  logic [31:0] imem [0:255];
  logic [31:0] m_pc = '0;
  logic        m_halted = 1'b0;
  logic        force_halt = 1'b0;
  logic [31:0] cur_instr;

  assign cur_instr  = imem[m_pc[9:2]];
  assign cpu_pc     = m_pc;
  assign cpu_halted = m_halted | force_halt;

  always @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  always @(posedge clk) begin
    if (cpu_rst) begin
      m_pc     <= '0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      case (cur_instr[31:26])
        6'h3F:   begin m_halted <= 1'b1; m_pc <= m_pc + 32'd4; end
        6'h02:   m_pc <= {4'b0, cur_instr[25:0], 2'b00};
        default: m_pc <= m_pc + 32'd4;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    tick();
    tick();
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(cycle_count), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_final_pc", 64'(final_pc), 64'd0);
    rst = 1'b0;

    // Program load {ADDI ; HALT}
    host_we = 1'b1; host_addr = 8'd0; host_wdata = InstrAddi;
    tick();
    check("load0_we", 64'(imem_we), 64'd1);
    check("load0_addr", 64'(imem_waddr), 64'd0);
    check("load0_data", 64'(imem_wdata), 64'(InstrAddi));
    host_addr = 8'd1; host_wdata = InstrHalt;
    tick();
    check("load1_addr", 64'(imem_waddr), 64'd1);
    host_we = 1'b0;
    tick();
    check("load_idle_we", 64'(imem_we), 64'd0);

    // Run to HALT
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold1_busy", 64'(busy), 64'd1);
    check("hold1_cpu_rst", 64'(cpu_rst), 64'd1);
    tick();
    check("hold2_cpu_rst", 64'(cpu_rst), 64'd1);
    tick();
    check("run_cpu_rst", 64'(cpu_rst), 64'd0);
    check("run_busy", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    check("halt_reached", 64'(n < 50), 64'd1);
    check("halt_done", 64'(done), 64'd1);
    check("halt_count", 64'(cycle_count), 64'd2);
    check("halt_final_pc", 64'(final_pc), 64'h8);
    check("halt_cpu_rst", 64'(cpu_rst), 64'd0);
    check("halt_busy", 64'(busy), 64'd0);
    check("halt_timeout", 64'(timeout), 64'd0);

    // Restart from DONE, with a rejected host write during RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done_clr", 64'(done), 64'd0);
    check("restart_count_clr", 64'(cycle_count), 64'd0);
    check("restart_pc_clr", 64'(final_pc), 64'd0);
    n = 0;
    while (cpu_rst && n < 20) begin tick(); n++; end
    check("restart_run", 64'(n < 20), 64'd1);
    host_we = 1'b1; host_addr = 8'd5; host_wdata = 32'hDEAD_BEEF;
    tick();
    host_we = 1'b0;
    check("rej_imem_we", 64'(imem_we), 64'd0);
    check("rej_pulse", 64'(load_rej), 64'd1);
    tick();
    check("rej_pulse_end", 64'(load_rej), 64'd0);
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    check("rerun_done", 64'(done), 64'd1);
    check("rerun_count", 64'(cycle_count), 64'd2);
    check("rerun_final_pc", 64'(final_pc), 64'h8);

    // Abort on RUN cycle 3 with cpu_halted high
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (cpu_rst && n < 20) begin tick(); n++; end
    tick();
    tick();
    abort = 1'b1; force_halt = 1'b1;
    tick();
    abort = 1'b0; force_halt = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_timeout", 64'(timeout), 64'd0);
    check("abort_cpu_rst", 64'(cpu_rst), 64'd1);
    check("abort_count", 64'(cycle_count), 64'd2);

    // Load JMP 0 in the same idle cycle as start, then run into the timeout
    host_we = 1'b1; host_addr = 8'd0; host_wdata = InstrJmp0; start = 1'b1;
    tick();
    host_we = 1'b0; start = 1'b0;
    check("same_cyc_we", 64'(imem_we), 64'd1);
    check("same_cyc_busy", 64'(busy), 64'd1);
    n = 0;
    while (cpu_rst && n < 20) begin tick(); n++; end
    tick();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_busy", 64'(busy), 64'd1);
    check("start_ignored_count", 64'(cycle_count), 64'd4);
    n = 0;
    while (!timeout && n < 100) begin tick(); n++; end
    check("tmo_reached", 64'(n < 100), 64'd1);
    check("tmo_flag", 64'(timeout), 64'd1);
    check("tmo_done", 64'(done), 64'd0);
    check("tmo_count", 64'(cycle_count), 64'd16);
    check("tmo_cpu_rst", 64'(cpu_rst), 64'd1);
    check("tmo_busy", 64'(busy), 64'd0);
    check("tmo_final_pc", 64'(final_pc), 64'd0);

    // Abort from TMO keeps the result
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("tmo_abort_flag", 64'(timeout), 64'd1);
    check("tmo_abort_count", 64'(cycle_count), 64'd16);

    // Mid-run reset
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clr_tmo", 64'(timeout), 64'd0);
    n = 0;
    while (cpu_rst && n < 20) begin tick(); n++; end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_count", 64'(cycle_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
